// File: rtl/mux_a1_if.sv
// Bus bundle for mux_a1: operand inputs, capture enable, and selected/registered outputs.
// Zero/negative flag wires are present only when MUX_A1_FLAGS_EN is defined.
interface mux_a1_if #(
  parameter int bits = 8
);
  logic            S_reg;
  logic [bits-1:0] out;
  logic [bits-1:0] custom_input;
  logic            en;
  logic [bits-1:0] mux_out;
  logic [bits-1:0] mux_q;
  logic            q_valid;
`ifdef MUX_A1_FLAGS_EN
  logic            zero_q;
  logic            neg_q;
`endif

  modport master (
    output S_reg,
    output out,
    output custom_input,
    output en,
    input  mux_out,
    input  mux_q,
`ifdef MUX_A1_FLAGS_EN
    input  zero_q,
    input  neg_q,
`endif
    input  q_valid
  );

  modport slave (
    input  S_reg,
    input  out,
    input  custom_input,
    input  en,
    output mux_out,
    output mux_q,
`ifdef MUX_A1_FLAGS_EN
    output zero_q,
    output neg_q,
`endif
    output q_valid
  );
endinterface

// File: rtl/mux_a1.sv
// Operand-select stage for the register-file write port: combinational select plus a registered copy.
// Define MUX_A1_FLAGS_EN to add registered zero/negative flags of the last captured value.
module mux_a1 #(
  parameter int bits = 8
) (
  input  logic     clk,
  input  logic     rst,
  mux_a1_if.slave  bus
);
  logic [bits-1:0] sel_value;
  logic [bits-1:0] mux_d;
  logic [bits-1:0] mux_q;
  logic            valid_d;
  logic            valid_q;

  // Ternary keeps X/Z on the unselected operand from leaking through.
  assign sel_value   = bus.S_reg ? bus.custom_input : bus.out;
  assign bus.mux_out = sel_value;

  always_comb begin
    mux_d   = mux_q;
    valid_d = 1'b0;
    if (bus.en) begin
      mux_d   = sel_value;
      valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mux_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      mux_q   <= mux_d;
      valid_q <= valid_d;
    end
  end

  assign bus.mux_q   = mux_q;
  assign bus.q_valid = valid_q;

`ifdef MUX_A1_FLAGS_EN
  logic zero_d;
  logic zero_q;
  logic neg_d;
  logic neg_q;

  // Flags describe the last capture only, so reset clears zero_q despite mux_q being 0.
  always_comb begin
    zero_d = zero_q;
    neg_d  = neg_q;
    if (bus.en) begin
      zero_d = (sel_value == '0);
      neg_d  = sel_value[bits-1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      zero_q <= 1'b0;
      neg_q  <= 1'b0;
    end else begin
      zero_q <= zero_d;
      neg_q  <= neg_d;
    end
  end

  assign bus.zero_q = zero_q;
  assign bus.neg_q  = neg_q;
`endif
endmodule

// File: tb/tb_mux_a1.sv
// Self-checking bench for mux_a1: directed test-plan cases plus randomized traffic against a reference model.
// Flag checks are compiled in only when MUX_A1_FLAGS_EN is defined.
module tb_mux_a1;
  localparam int BITS = 8;

  logic clk;
  logic rst;
  int   total;
  int   bad;
  bit   model_ready;

  logic [BITS-1:0] m_q;
  logic            m_v;
  logic            m_z;
  logic            m_n;

  mux_a1_if #(.bits(BITS)) bus ();

  mux_a1 #(.bits(BITS)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s actual=0x%0h expected=0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic s, input logic [BITS-1:0] o, input logic [BITS-1:0] c,
                               input logic e, input logic r);
    bus.S_reg        = s;
    bus.out          = o;
    bus.custom_input = c;
    bus.en           = e;
    rst              = r;
  endtask

  task automatic stepCycle();
    @(posedge clk);
    #1;
  endtask

  // Reference model: each edge either clears, captures the chosen operand, or just drops the pulse.
  always @(posedge clk) begin
    if (rst) begin
      m_q = '0;
      m_v = 1'b0;
      m_z = 1'b0;
      m_n = 1'b0;
      model_ready = 1'b1;
    end else if (bus.en) begin
      m_q = (bus.S_reg === 1'b1) ? bus.custom_input : bus.out;
      m_v = 1'b1;
      m_z = (m_q == 0);
      m_n = ((m_q >> (BITS - 1)) & 1) != 0;
    end else begin
      m_v = 1'b0;
    end
  end

  always @(negedge clk) begin
    if (model_ready) begin
      checkOutput("mux_out", bus.mux_out, (bus.S_reg === 1'b1) ? bus.custom_input : bus.out);
      checkOutput("mux_q", bus.mux_q, m_q);
      checkOutput("q_valid", bus.q_valid, m_v);
`ifdef MUX_A1_FLAGS_EN
      checkOutput("zero_q", bus.zero_q, m_z);
      checkOutput("neg_q", bus.neg_q, m_n);
`endif
    end
  end

  initial begin
    logic [BITS-1:0] ro;
    logic [BITS-1:0] rc;
    logic [BITS-1:0] expv;
    logic            rs;
    logic            re;
    logic            rr;

    total = 0;
    bad   = 0;
    model_ready = 1'b0;
    applyStimulus(1'b0, '0, '0, 1'b0, 1'b1);
    repeat (2) stepCycle();

    checkOutput("reset_mux_q", bus.mux_q, 0);
    checkOutput("reset_q_valid", bus.q_valid, 0);
`ifdef MUX_A1_FLAGS_EN
    checkOutput("reset_zero_q", bus.zero_q, 0);
    checkOutput("reset_neg_q", bus.neg_q, 0);
`endif

    $display("[TB] directed cases");
    applyStimulus(1'b1, 8'hCC, 8'h33, 1'b1, 1'b0);
    #2 checkOutput("tp1_mux_out", bus.mux_out, 8'h33);
    stepCycle();
    checkOutput("tp1_mux_q", bus.mux_q, 8'h33);
    checkOutput("tp1_q_valid", bus.q_valid, 1);

    applyStimulus(1'b1, 8'hF1, 8'hE6, 1'b1, 1'b0);
    #2 checkOutput("tp2_mux_out", bus.mux_out, 8'hE6);
    stepCycle();
    checkOutput("tp2_mux_q", bus.mux_q, 8'hE6);
`ifdef MUX_A1_FLAGS_EN
    checkOutput("tp2_neg_q", bus.neg_q, 1);
    checkOutput("tp2_zero_q", bus.zero_q, 0);
`endif

    applyStimulus(1'b0, 8'hCC, 8'h33, 1'b1, 1'b0);
    #2 checkOutput("tp3_mux_out", bus.mux_out, 8'hCC);
    stepCycle();
    checkOutput("tp3_mux_q", bus.mux_q, 8'hCC);
    applyStimulus(1'b1, 8'h11, 8'h22, 1'b0, 1'b0);
    #2 checkOutput("tp3_mux_out_hold", bus.mux_out, 8'h22);
    stepCycle();
    checkOutput("tp3_mux_q_hold", bus.mux_q, 8'hCC);
    checkOutput("tp3_q_valid_low", bus.q_valid, 0);

    applyStimulus(1'b0, 8'h00, 8'hE2, 1'b1, 1'b0);
    #2 checkOutput("tp4_mux_out", bus.mux_out, 8'h00);
    stepCycle();
    checkOutput("tp4_mux_q", bus.mux_q, 8'h00);
`ifdef MUX_A1_FLAGS_EN
    checkOutput("tp4_zero_q", bus.zero_q, 1);
    checkOutput("tp4_neg_q", bus.neg_q, 0);
`endif

    applyStimulus(1'b0, 8'hAA, 8'hFF, 1'b1, 1'b1);
    #2 checkOutput("tp5_mux_out", bus.mux_out, 8'hAA);
    stepCycle();
    checkOutput("tp5_mux_q_rst", bus.mux_q, 0);
    checkOutput("tp5_q_valid_rst", bus.q_valid, 0);
`ifdef MUX_A1_FLAGS_EN
    checkOutput("tp5_zero_q_rst", bus.zero_q, 0);
    checkOutput("tp5_neg_q_rst", bus.neg_q, 0);
`endif
    applyStimulus(1'b0, 8'hAA, 8'hFF, 1'b1, 1'b0);
    stepCycle();
    checkOutput("tp5_mux_q_after", bus.mux_q, 8'hAA);
    checkOutput("tp5_q_valid_after", bus.q_valid, 1);

    for (int i = 0; i < 3; i++) begin
      rs = (i % 2) != 0;
      ro = BITS'(8'h10 + i);
      rc = BITS'(8'hA0 + i);
      expv = rs ? rc : ro;
      applyStimulus(rs, ro, rc, 1'b1, 1'b0);
      stepCycle();
      checkOutput("tp6_q_valid", bus.q_valid, 1);
      checkOutput("tp6_mux_q", bus.mux_q, expv);
    end

    $display("[TB] randomized traffic");
    for (int i = 0; i < 400; i++) begin
      rs = $urandom_range(0, 1) != 0;
      ro = BITS'($urandom());
      rc = BITS'($urandom());
      if ($urandom_range(0, 7) == 0) ro = '0;
      if ($urandom_range(0, 7) == 0) rc = '0;
      re = $urandom_range(0, 9) < 7;
      rr = $urandom_range(0, 19) == 0;
      applyStimulus(rs, ro, rc, re, rr);
      stepCycle();
    end

    applyStimulus(1'b0, '0, '0, 1'b0, 1'b0);
    stepCycle();
    @(negedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
